seq_magnitude_comparator: RTL and testbench

- Multi-cycle, parametrised magnitude comparator for the calculator datapath, replacing fixed-width combinational compare on wide operands.
- Latches two WIDTH-bit operands on a start strobe and compares them DIGIT bits per cycle, most significant digit first.
- Stops early at the first differing digit, supports signed (two's complement) and unsigned modes, and reports eq/lt/gt with a one-cycle done pulse.

---
 rtl/seq_magnitude_comparator_pkg.sv | 18 +
 rtl/seq_magnitude_comparator_compare_digit.sv | 24 ++
 rtl/seq_magnitude_comparator.sv | 138 +++++++++++++
 tb/tb_seq_magnitude_comparator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/seq_magnitude_comparator_pkg.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator_pkg
// Shared definitions for the sequential magnitude comparator:
//   state_t   - FSM state encoding (S_IDLE = 0, S_COMPARE = 1)
//   idx_bits  - width of the digit index register, max(1, clog2(n))
// ---------------------------------------------------------------------------
package seq_magnitude_comparator_pkg;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COMPARE = 1'b1
    } state_t;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_magnitude_comparator_compare_digit.sv
// ---------------------------------------------------------------------------
// compare_digit
// Purely combinational W-bit unsigned magnitude comparator.
// Ports:
//   a, b   in  W  digits to compare
//   eq     out 1  a == b
//   lt     out 1  a <  b
//   gt     out 1  a >  b
// ---------------------------------------------------------------------------
module compare_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    assign eq = (a == b);
    assign lt = (a < b);
    assign gt = (a > b);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
// Multi-cycle magnitude comparator. Operands are latched on start and
// compared DIGIT bits per cycle, most significant digit first, stopping at
// the first differing digit. Signed mode flips the operand MSBs at capture so
// that two's-complement order becomes plain unsigned order.
// Ports:
//   clk          in  1      rising-edge clock
//   rst          in  1      asynchronous active-high reset
//   start        in  1      request strobe, accepted only in IDLE
//   signed_mode  in  1      1 = two's complement, 0 = unsigned
//   a, b         in  WIDTH  operands, sampled with start
//   busy         out 1      high while comparing
//   done         out 1      one-cycle pulse when eq/lt/gt become valid
//   eq, lt, gt   out 1      result flags, held until the next accepted start
//
// Handshake: a request is taken on any rising edge where start=1 and busy=0
// (including the cycle done is high). The result is then valid from the
// cycle done pulses until the next accepted request; while busy all flags
// read 0 and start is ignored.
// ---------------------------------------------------------------------------
module seq_magnitude_comparator
    import seq_magnitude_comparator_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             lt,
    output logic             gt
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = idx_bits(N);
    localparam logic [IW-1:0]    IDX_TOP  = IW'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] op_a, op_a_n;
    logic [WIDTH-1:0] op_b, op_b_n;
    logic [IW-1:0]    idx, idx_n;
    logic             eq_n, lt_n, gt_n, done_n;

    logic [DIGIT-1:0] dig_a, dig_b;
    logic             dig_eq, dig_lt, dig_gt;

    // Current digit mux: constant part-selects keyed on the index.
    always_comb begin
        dig_a = '0;
        dig_b = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == IW'(i)) begin
                dig_a = op_a[i*DIGIT +: DIGIT];
                dig_b = op_b[i*DIGIT +: DIGIT];
            end
        end
    end

    compare_digit #(.W(DIGIT)) u_compare_digit (
        .a  (dig_a),
        .b  (dig_b),
        .eq (dig_eq),
        .lt (dig_lt),
        .gt (dig_gt)
    );

    always_comb begin
        state_n = state;
        op_a_n  = op_a;
        op_b_n  = op_b;
        idx_n   = idx;
        eq_n    = eq;
        lt_n    = lt;
        gt_n    = gt;
        done_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    op_a_n  = a ^ (signed_mode ? MSB_MASK : '0);
                    op_b_n  = b ^ (signed_mode ? MSB_MASK : '0);
                    idx_n   = IDX_TOP;
                    eq_n    = 1'b0;
                    lt_n    = 1'b0;
                    gt_n    = 1'b0;
                    state_n = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (!dig_eq) begin
                    lt_n    = dig_lt;
                    gt_n    = dig_gt;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (idx == '0) begin
                    eq_n    = 1'b1;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else begin
                    idx_n = idx - IW'(1);
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_a  <= '0;
            op_b  <= '0;
            idx   <= '0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            gt    <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            op_a  <= op_a_n;
            op_b  <= op_b_n;
            idx   <= idx_n;
            eq    <= eq_n;
            lt    <= lt_n;
            gt    <= gt_n;
            done  <= done_n;
        end
    end

    assign busy = (state == S_COMPARE);

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
// Two instances: 8-bit/4-bit-digit and 32-bit/4-bit-digit. Each request
// pushes {expected done cycle, eq, lt, gt} into that instance's queue; a
// monitor pops and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

    localparam logic [2:0] F_EQ = 3'b100;
    localparam logic [2:0] F_LT = 3'b010;
    localparam logic [2:0] F_GT = 3'b001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cyc = 0;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, eq8, lt8, gt8;

    logic        start32 = 1'b0, sm32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, eq32, lt32, gt32;

    logic [34:0] exp8_q[$];
    logic [34:0] exp32_q[$];

    int n_vec = 0;
    int n_bad = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_magnitude_comparator #(.WIDTH(8), .DIGIT(4)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .busy(busy8), .done(done8),
        .eq(eq8), .lt(lt8), .gt(gt8)
    );

    seq_magnitude_comparator #(.WIDTH(32), .DIGIT(4)) u32 (
        .clk(clk), .rst(rst), .start(start32), .signed_mode(sm32),
        .a(a32), .b(b32), .busy(busy32), .done(done32),
        .eq(eq32), .lt(lt32), .gt(gt32)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (done8) begin
            if (exp8_q.size() == 0) begin
                check("u8_unexpected_done", 64'(done8), 64'(0));
            end else begin
                logic [34:0] e;
                e = exp8_q.pop_front();
                check("u8_flags", 64'({eq8, lt8, gt8}), 64'(e[2:0]));
                check("u8_done_cycle", 64'(cyc), 64'(e[34:3]));
            end
        end
        if (done32) begin
            if (exp32_q.size() == 0) begin
                check("u32_unexpected_done", 64'(done32), 64'(0));
            end else begin
                logic [34:0] e;
                e = exp32_q.pop_front();
                check("u32_flags", 64'({eq32, lt32, gt32}), 64'(e[2:0]));
                check("u32_done_cycle", 64'(cyc), 64'(e[34:3]));
            end
        end
    end

    // ---------------- drivers ----------------
    // Called between edges; the request is taken at the next rising edge E0
    // and the result is expected during cycle E0+k.
    task automatic issue8(input logic [7:0] va, input logic [7:0] vb, input logic s,
                          input int k, input logic [2:0] flags);
        a8 = va; b8 = vb; sm8 = s; start8 = 1'b1;
        exp8_q.push_back({cyc + 32'(1 + k), flags});
        @(posedge clk); #1;
        start8 = 1'b0;
        check("u8_busy_after_start", 64'(busy8), 64'(1));
        check("u8_flags_clear_busy", 64'({eq8, lt8, gt8}), 64'(0));
    endtask

    task automatic issue32(input logic [31:0] va, input logic [31:0] vb, input logic s,
                           input int k, input logic [2:0] flags);
        a32 = va; b32 = vb; sm32 = s; start32 = 1'b1;
        exp32_q.push_back({cyc + 32'(1 + k), flags});
        @(posedge clk); #1;
        start32 = 1'b0;
        check("u32_busy_after_start", 64'(busy32), 64'(1));
    endtask

    task automatic wait_done8();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        if (!seen) check("u8_done_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_done32();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done32) seen = 1'b1;
        end
        if (!seen) check("u32_done_timeout", 64'(0), 64'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_u8_outputs", 64'({busy8, done8, eq8, lt8, gt8}), 64'(0));
        check("reset_u32_outputs", 64'({busy32, done32, eq32, lt32, gt32}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 8-bit directed vectors; each new start lands on the previous done cycle.
        issue8(8'h3C, 8'h3C, 1'b0, 2, F_EQ);   wait_done8();
        issue8(8'h5A, 8'h3A, 1'b0, 1, F_GT);   wait_done8();
        issue8(8'h35, 8'h3A, 1'b0, 2, F_LT);   wait_done8();
        issue8(8'hFF, 8'h01, 1'b1, 1, F_LT);   wait_done8();
        issue8(8'hFF, 8'h01, 1'b0, 1, F_GT);   wait_done8();
        issue8(8'h80, 8'h7F, 1'b1, 1, F_LT);   wait_done8();
        issue8(8'h85, 8'h8A, 1'b1, 2, F_LT);   wait_done8();
        issue8(8'hF0, 8'hF0, 1'b1, 2, F_EQ);   wait_done8();
        issue8(8'h00, 8'h01, 1'b0, 2, F_LT);   wait_done8();

        // Result held after done, no second pulse.
        repeat (2) @(posedge clk);
        #1;
        check("u8_hold_flags", 64'({done8, busy8, eq8, lt8, gt8}), 64'({2'b00, F_LT}));

        // 32-bit equal compare with an ignored start while busy.
        issue32(32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 8, F_EQ);
        @(posedge clk); #1;
        a32 = 32'h0; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        check("u32_busy_ignores_start", 64'(busy32), 64'(1));
        wait_done32();
        // Back-to-back on the done cycle.
        issue32(32'h12345678, 32'h12345679, 1'b0, 8, F_LT);
        wait_done32();
        issue32(32'h80000000, 32'h00000000, 1'b1, 1, F_LT);
        wait_done32();
        @(posedge clk); #1;

        // Asynchronous abort during an equal compare.
        issue32(32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 8, F_EQ);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp32_q.delete();
        #1;
        check("u32_abort_outputs", 64'({busy32, done32, eq32, lt32, gt32}), 64'(0));
        @(posedge clk); #1;
        check("u32_abort_no_done", 64'({busy32, done32}), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        issue32(32'h00000001, 32'h00000002, 1'b0, 8, F_LT);
        wait_done32();

        repeat (3) @(posedge clk);
        #1;
        check("u8_queue_drained", 64'(exp8_q.size()), 64'(0));
        check("u32_queue_drained", 64'(exp32_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
